// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg
//   Shared constants for the processing-run controller: the FSM state
//   encoding (mirrored by the CPU-side software header) and the default
//   widths.
//   Optional feature macro used by the controller: PROC_RUN_TIMEOUT_EN.
package proc_ctrl_pkg;

  localparam int CNT_W_DEFAULT    = 32;
  localparam int SETTLE_W_DEFAULT = 16;
  // Shared settle/drain/watchdog timer; must be at least SETTLE_W and 32 wide.
  localparam int TMR_W            = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/run_cycle_timer.sv
// run_cycle_timer
//   Loadable down-counter with a zero flag. The load value is the number of
//   additional cycles to wait, so a load of N gives zero_o after N decrements.
//   Ports:
//     clk, reset_n  clock / async active-low reset
//     load_i        load load_val_i (wins over dec_i)
//     load_val_i    value to load
//     dec_i         decrement, saturating at zero
//     zero_o        counter is zero
module run_cycle_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/proc_run_controller.sv
// proc_run_controller
//   Sequences one datapath processing run for the soft CPU: datapath reset
//   for a settle time, enable while collecting n_results strobes, pipeline
//   drain, then a sticky done flag that the CPU polls.
//   Optional watchdog on RUN length: define PROC_RUN_TIMEOUT_EN.
//   Ports:
//     clk, reset_n     clock / async active-low reset
//     start            CPU enable level, rising edge starts a run
//     abort            synchronous abort, highest priority
//     n_results        strobes to collect (latched at start)
//     settle_cycles    datapath reset length, 0 treated as 1 (latched at start)
//     timeout_cycles   RUN watchdog limit, 0 disables (watchdog build only)
//     result_valid     one strobe per datapath result
//     dp_reset         datapath / FIFO synchronous reset
//     dp_enable        datapath enable
//     busy, done       run in progress / run finished
//     timed_out        run ended by watchdog
//     result_count     results collected in current/last run
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | waiting for a start edge, everything low
//   ST_CLEAR | dp_reset high for the settle time
//   ST_RUN   | dp_enable high, counting result strobes
//   ST_DRAIN | dp_enable low for DRAIN_CYCLES, pipeline flush
//   ST_DONE  | done high, count held; start edge re-arms
module proc_run_controller #(
  parameter int CNT_W        = proc_ctrl_pkg::CNT_W_DEFAULT,
  parameter int SETTLE_W     = proc_ctrl_pkg::SETTLE_W_DEFAULT,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    n_results,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [31:0]         timeout_cycles,
  input  logic                result_valid,
  output logic                dp_reset,
  output logic                dp_enable,
  output logic                busy,
  output logic                done,
  output logic                timed_out,
  output logic [CNT_W-1:0]    result_count
);

  import proc_ctrl_pkg::*;

  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);

  state_t            state_q, state_d;
  logic              start_q;
  logic              start_edge;
  logic              launch;
  logic [CNT_W-1:0]  n_res_q;
  logic [CNT_W-1:0]  count_q, count_d, count_inc;
  logic              timed_out_q, timed_out_d;
  logic              dp_reset_q, dp_reset_d;
  logic              dp_enable_q, dp_enable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;

`ifdef PROC_RUN_TIMEOUT_EN
  logic [31:0]       timeout_q;
`else
  logic              unused_timeout;
  assign unused_timeout = ^timeout_cycles;
`endif

  assign start_edge = start & ~start_q;
  assign count_inc  = count_q + CNT_W'(1);

  run_cycle_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // State register plus latched run parameters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      n_res_q     <= '0;
      count_q     <= '0;
      timed_out_q <= 1'b0;
`ifdef PROC_RUN_TIMEOUT_EN
      timeout_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      count_q     <= count_d;
      timed_out_q <= timed_out_d;
      if (launch) begin
        n_res_q   <= n_results;
`ifdef PROC_RUN_TIMEOUT_EN
        timeout_q <= timeout_cycles;
`endif
      end
    end
  end

  // Next state, result counter and timer control.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    timed_out_d = timed_out_q;
    launch      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          launch      = 1'b1;
          state_d     = ST_CLEAR;
          count_d     = '0;
          timed_out_d = 1'b0;
          tmr_load    = 1'b1;
          // timer counts extra cycles, so settle of 0 and 1 both give one cycle
          tmr_val     = (settle_cycles == '0) ? '0 : TMR_W'(settle_cycles) - TMR_W'(1);
        end
      end
      ST_CLEAR: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (n_res_q == '0) begin
            state_d = ST_DRAIN;
            tmr_val = DRAIN_LOAD;
          end else begin
            state_d = ST_RUN;
`ifdef PROC_RUN_TIMEOUT_EN
            tmr_val = timeout_q - 32'd1;
`endif
          end
        end
      end
      ST_RUN: begin
        if (result_valid) count_d = count_inc;
        // completion takes priority over a watchdog expiring in the same cycle
        if (result_valid && (count_inc == n_res_q)) begin
          state_d  = ST_DRAIN;
          tmr_load = 1'b1;
          tmr_val  = DRAIN_LOAD;
        end
`ifdef PROC_RUN_TIMEOUT_EN
        else if ((timeout_q != '0) && tmr_zero) begin
          state_d     = ST_DRAIN;
          timed_out_d = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = DRAIN_LOAD;
        end
`endif
      end
      ST_DRAIN: begin
        if (tmr_zero) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d     = ST_IDLE;
      count_d     = '0;
      timed_out_d = 1'b0;
      launch      = 1'b0;
    end
    tmr_dec = !tmr_load &&
              ((state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_DRAIN));
  end

  // Outputs decoded from the next state so they are registered yet aligned with state_q.
  always_comb begin
    dp_reset_d  = (state_d == ST_CLEAR);
    dp_enable_d = (state_d == ST_RUN);
    busy_d      = (state_d == ST_CLEAR) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_reset_q  <= 1'b0;
      dp_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dp_reset_q  <= dp_reset_d;
      dp_enable_q <= dp_enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dp_reset     = dp_reset_q;
  assign dp_enable    = dp_enable_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timed_out    = timed_out_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_proc_run_controller.sv
// Bench for proc_run_controller. The reference model describes a run by
// its timeline (launch edge, settle length, edge that ends RUN) and derives
// every output from cycle arithmetic on that timeline.
module tb_proc_run_controller;

  localparam int D = 4;
  localparam longint NEVER = 64'h0000_1000_0000_0000;
`ifdef PROC_RUN_TIMEOUT_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] n_results = '0;
  logic [15:0] settle_cycles = '0;
  logic [31:0] timeout_cycles = '0;
  logic        result_valid = 1'b0;
  logic        dp_reset, dp_enable, busy, done, timed_out;
  logic [31:0] result_count;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int rst_cycles = 0, en_cycles = 0, busy_cycles = 0;

  proc_run_controller #(.CNT_W(32), .SETTLE_W(16), .DRAIN_CYCLES(D)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .n_results      (n_results),
    .settle_cycles  (settle_cycles),
    .timeout_cycles (timeout_cycles),
    .result_valid   (result_valid),
    .dp_reset       (dp_reset),
    .dp_enable      (dp_enable),
    .busy           (busy),
    .done           (done),
    .timed_out      (timed_out),
    .result_count   (result_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  longint cyc = 0, t0 = 0, t_end = NEVER;
  longint s_m = 1, n_m = 0, to_m = 0, cnt_m = 0;
  bit launched = 1'b0, tout_m = 1'b0, st_prev = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      launched = 1'b0; cnt_m = 0; tout_m = 1'b0; t_end = NEVER; cyc = 0;
    end else begin
      cyc++;
      if (abort) begin
        launched = 1'b0; cnt_m = 0; tout_m = 1'b0; t_end = NEVER;
      end else if (start && !st_prev && (!launched || (cyc - 1 >= t_end + D))) begin
        launched = 1'b1; t0 = cyc; t_end = NEVER; cnt_m = 0; tout_m = 1'b0;
        s_m  = (settle_cycles == 0) ? 1 : longint'(settle_cycles);
        n_m  = longint'(n_results);
        to_m = longint'(timeout_cycles);
      end else if (launched && t_end == NEVER) begin
        if (n_m == 0) begin
          if (cyc == t0 + s_m) t_end = cyc;
        end else if (cyc - 1 >= t0 + s_m) begin
          if (result_valid) begin
            cnt_m++;
            if (cnt_m == n_m) t_end = cyc;
          end
          if (WDOG && t_end == NEVER && to_m != 0 && cyc - (t0 + s_m) == to_m) begin
            t_end = cyc; tout_m = 1'b1;
          end
        end
      end
    end
    st_prev = start;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dp_reset",     dp_reset,     launched && cyc < t0 + s_m);
      chk("dp_enable",    dp_enable,    launched && n_m != 0 && cyc >= t0 + s_m && cyc < t_end);
      chk("busy",         busy,         launched && cyc < t_end + D);
      chk("done",         done,         launched && cyc >= t_end + D);
      chk("timed_out",    timed_out,    launched && tout_m);
      chk("result_count", result_count, cnt_m);
      if (dp_reset)  rst_cycles++;
      if (dp_enable) en_cycles++;
      if (busy)      busy_cycles++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic launch(input int n, input int s, input int to);
    start = 1'b0;
    tick(1);
    n_results = n; settle_cycles = 16'(s); timeout_cycles = to;
    rst_cycles = 0; en_cycles = 0; busy_cycles = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done !== 1'b1; i++) tick(1);
    chk("wait_done", done, 1);
  endtask

  task automatic wait_en(input int limit);
    for (int i = 0; i < limit && dp_enable !== 1'b1; i++) tick(1);
    chk("wait_enable", dp_enable, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    tick(3);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick(1);
    chk("rst_busy", busy, 0);
    chk("rst_count", result_count, 0);

    // 1: n=5, settle=3, strobes every 2 cycles
    launch(5, 3, 0);
    wait_en(20);
    for (int i = 0; i < 5; i++) begin
      result_valid = 1'b1;
      tick(1);
      result_valid = 1'b0;
      if (i == 4) begin
        chk("t1_en_low_after_last", dp_enable, 0);
        tick(D - 1);
        chk("t1_done_not_yet", done, 0);
        tick(1);
        chk("t1_done_latency", done, 1);
      end else begin
        tick(1);
      end
    end
    wait_done(30);
    chk("t1_count", result_count, 5);
    chk("t1_reset_len", rst_cycles, 3);

    // 2: n=0, settle=0
    launch(0, 0, 0);
    wait_done(20);
    chk("t2_reset_len", rst_cycles, 1);
    chk("t2_enable_len", en_cycles, 0);
    chk("t2_busy_len", busy_cycles, 1 + D);
    chk("t2_count", result_count, 0);

    // 3: n=3, six back-to-back strobes
    launch(3, 2, 0);
    wait_en(20);
    result_valid = 1'b1;
    tick(6);
    result_valid = 1'b0;
    wait_done(20);
    chk("t3_count", result_count, 3);

    // 4: abort with a strobe at count 2, start held through it
    launch(5, 1, 0);
    wait_en(20);
    start = 1'b1;
    result_valid = 1'b1;
    tick(2);
    chk("t4_count_before_abort", result_count, 2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    result_valid = 1'b0;
    chk("t4_abort_count", result_count, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_abort_busy", busy, 0);
    tick(5);
    chk("t4_held_no_retrigger", busy, 0);
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    chk("t4_new_edge_runs", dp_reset, 1);
    start = 1'b0;
    wait_en(20);
    result_valid = 1'b1;
    tick(5);
    result_valid = 1'b0;
    wait_done(20);
    chk("t4_count", result_count, 5);

    // 5: start edge and parameter changes mid-run
    launch(4, 2, 0);
    wait_en(20);
    n_results = 1; settle_cycles = 9;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    tick(1);
    chk("t5_still_enabled", dp_enable, 1);
    chk("t5_count_mid", result_count, 1);
    result_valid = 1'b1;
    tick(3);
    result_valid = 1'b0;
    wait_done(20);
    chk("t5_count", result_count, 4);

    // 6: watchdog with no strobes
    launch(100, 1, 10);
`ifdef PROC_RUN_TIMEOUT_EN
    wait_done(60);
    chk("t6_timed_out", timed_out, 1);
    chk("t6_count", result_count, 0);
`else
    tick(200);
    chk("t6_busy_forever", busy, 1);
    chk("t6_no_done", done, 0);
    chk("t6_no_timed_out", timed_out, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t6_abort_idle", busy, 0);
`endif
    tick(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
